sar_adc4: RTL and testbench

Successive-approximation ADC controller, the input-side counterpart of `dac4`. It samples an 8-bit input level and binary-searches a 4-bit code by driving `dac4.code` and comparing `dac4.analog_out` against the sample. The 4-bit result goes to downstream logic with a one-cycle `done` pulse. It sits beside `dac4`: `dac_code` connects to `dac4.code`, and `dac4.analog_out` connects back to `dac_level`.

---
 rtl/sar_adc4_pkg.sv | 15 +
 rtl/sar_adc4_if.sv | 26 ++
 rtl/sar_adc4_settle_timer.sv | 32 +++
 rtl/sar_adc4.sv | 115 +++++++++++
 tb/tb_sar_adc4.sv | 256 +++++++++++++++++++++++++
 5 files changed

// File: rtl/sar_adc4_pkg.sv
// Shared types and defaults for the 4-bit successive-approximation ADC controller.
package sar_adc_pkg;

  localparam int unsigned CodeWDefault  = 4;
  localparam int unsigned LevelWDefault = 8;
  localparam int unsigned SETTLE_W      = 4;

  typedef enum logic [1:0] {
    StIdle,
    StSample,
    StTrial,
    StResult
  } state_e;

endpackage

// File: rtl/sar_adc4_if.sv
// Conversion request/result signals plus the loop to the companion DAC.
interface sar_adc4_if
  import sar_adc_pkg::*;
#(
  parameter int unsigned CODE_W  = CodeWDefault,
  parameter int unsigned LEVEL_W = LevelWDefault
);
  logic               start;
  logic [LEVEL_W-1:0] analog_in;
  logic [CODE_W-1:0]  dac_code;
  logic [LEVEL_W-1:0] dac_level;
  logic               busy;
  logic               done;
  logic [CODE_W-1:0]  code;
  logic               valid;

  modport master (
    output start, analog_in, dac_level,
    input  dac_code, busy, done, code, valid
  );

  modport slave (
    input  start, analog_in, dac_level,
    output dac_code, busy, done, code, valid
  );
endinterface

// File: rtl/sar_adc4_settle_timer.sv
// Loadable down-counter; expire is high while the count sits at zero.
module sar_settle_timer
  import sar_adc_pkg::*;
(
  input  logic                clk,
  input  logic                rst,
  input  logic                load,
  input  logic                en,
  input  logic [SETTLE_W-1:0] load_val,
  output logic                expire
);
  logic [SETTLE_W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (load) begin
      cnt_d = load_val;
    end else if (en && (cnt_q != '0)) begin
      cnt_d = cnt_q - 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign expire = (cnt_q == '0);
endmodule

// File: rtl/sar_adc4.sv
// SAR ADC controller: samples a level and binary-searches a code through an external DAC.
module sar_adc4
  import sar_adc_pkg::*;
#(
  parameter int unsigned CODE_W     = CodeWDefault,
  parameter int unsigned LEVEL_W    = LevelWDefault,
  parameter int unsigned SETTLE_CYC = 1
) (
  input logic       clk,
  input logic       rst,
  sar_adc4_if.slave bus
);
  localparam int unsigned IdxW = (CODE_W > 1) ? $clog2(CODE_W) : 1;
  // Counter is loaded with SETTLE_CYC-1 so it reaches zero on the last settle cycle.
  localparam logic [SETTLE_W-1:0] SettleLoad = SETTLE_W'(SETTLE_CYC - 1);

  state_e             state_q, state_d;
  logic [LEVEL_W-1:0] sample_q, sample_d;
  logic [CODE_W-1:0]  trial_q, trial_d;
  logic [CODE_W-1:0]  code_q, code_d;
  logic [IdxW-1:0]    idx_q, idx_d;
  logic               busy_q, busy_d;
  logic               done_q, done_d;
  logic               valid_q, valid_d;
  logic               timer_load;
  logic               expire;

  sar_settle_timer u_settle_timer (
    .clk      (clk),
    .rst      (rst),
    .load     (timer_load),
    .en       (state_q == StTrial),
    .load_val (SettleLoad),
    .expire   (expire)
  );

  always_comb begin
    state_d    = state_q;
    sample_d   = sample_q;
    trial_d    = trial_q;
    code_d     = code_q;
    idx_d      = idx_q;
    busy_d     = busy_q;
    done_d     = 1'b0;
    valid_d    = valid_q;
    timer_load = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (bus.start) begin
          state_d = StSample;
          busy_d  = 1'b1;
          valid_d = 1'b0;
        end
      end
      StSample: begin
        sample_d           = bus.analog_in;
        trial_d            = '0;
        trial_d[CODE_W-1]  = 1'b1;
        idx_d              = IdxW'(CODE_W - 1);
        timer_load         = 1'b1;
        state_d            = StTrial;
      end
      StTrial: begin
        if (expire) begin
          if (sample_q < bus.dac_level) begin
            trial_d[idx_q] = 1'b0;
          end
          if (idx_q != '0) begin
            idx_d          = idx_q - 1'b1;
            trial_d[idx_d] = 1'b1;
            timer_load     = 1'b1;
          end else begin
            state_d = StResult;
          end
        end
      end
      StResult: begin
        code_d  = trial_q;
        done_d  = 1'b1;
        valid_d = 1'b1;
        busy_d  = 1'b0;
        state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= StIdle;
      sample_q <= '0;
      trial_q  <= '0;
      code_q   <= '0;
      idx_q    <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      valid_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      sample_q <= sample_d;
      trial_q  <= trial_d;
      code_q   <= code_d;
      idx_q    <= idx_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
      valid_q  <= valid_d;
    end
  end

  assign bus.dac_code = trial_q;
  assign bus.code     = code_q;
  assign bus.busy     = busy_q;
  assign bus.done     = done_q;
  assign bus.valid    = valid_q;
endmodule

// File: tb/tb_sar_adc4.sv
// Directed bench for sar_adc4 with a code*17 DAC model, at SETTLE_CYC of 1 and 3.
module tb_sar_adc4;
  logic clk = 1'b0;
  logic rst;
  int   vectors     = 0;
  int   miscompares = 0;

  sar_adc4_if #(.CODE_W(4), .LEVEL_W(8)) if1 ();
  sar_adc4_if #(.CODE_W(4), .LEVEL_W(8)) if3 ();

  assign if1.dac_level = {if1.dac_code, if1.dac_code};
  assign if3.dac_level = {if3.dac_code, if3.dac_code};

  sar_adc4 #(.CODE_W(4), .LEVEL_W(8), .SETTLE_CYC(1)) dut1 (
    .clk (clk),
    .rst (rst),
    .bus (if1.slave)
  );

  sar_adc4 #(.CODE_W(4), .LEVEL_W(8), .SETTLE_CYC(3)) dut3 (
    .clk (clk),
    .rst (rst),
    .bus (if3.slave)
  );

  always #5 clk = ~clk;

  // Starts a conversion on dut1 at the current negedge; lat is the edge index of done, -1 on timeout.
  task automatic run_conv(input logic [7:0] lvl, output logic [3:0] res, output int lat);
    if1.analog_in = lvl;
    if1.start     = 1'b1;
    @(negedge clk);
    if1.start = 1'b0;
    lat = -1;
    res = 4'd0;
    for (int n = 1; n <= 40; n++) begin
      @(negedge clk);
      if (if1.done) begin
        lat = n;
        res = if1.code;
        break;
      end
    end
  endtask

  task automatic test_reset();
    rst           = 1'b1;
    if1.start     = 1'b0;
    if1.analog_in = 8'd0;
    if3.start     = 1'b0;
    if3.analog_in = 8'd0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    vectors++; if (if1.dac_code !== 4'd0) begin miscompares++; $display("FAIL reset_dac_code: got %0d expected 0", if1.dac_code); end
    vectors++; if (if1.code !== 4'd0) begin miscompares++; $display("FAIL reset_code: got %0d expected 0", if1.code); end
    vectors++; if (if1.busy !== 1'b0) begin miscompares++; $display("FAIL reset_busy: got %0b expected 0", if1.busy); end
    vectors++; if (if1.done !== 1'b0) begin miscompares++; $display("FAIL reset_done: got %0b expected 0", if1.done); end
    vectors++; if (if1.valid !== 1'b0) begin miscompares++; $display("FAIL reset_valid: got %0b expected 0", if1.valid); end
    vectors++; if (if3.dac_code !== 4'd0) begin miscompares++; $display("FAIL reset3_dac_code: got %0d expected 0", if3.dac_code); end
    vectors++; if (if3.busy !== 1'b0) begin miscompares++; $display("FAIL reset3_busy: got %0b expected 0", if3.busy); end
    vectors++; if (if3.valid !== 1'b0) begin miscompares++; $display("FAIL reset3_valid: got %0b expected 0", if3.valid); end
  endtask

  task automatic test_basic();
    logic [3:0] exp_trial [4];
    exp_trial     = '{4'd8, 4'd4, 4'd6, 4'd5};
    if1.analog_in = 8'd100;
    if1.start     = 1'b1;
    @(negedge clk);
    if1.start = 1'b0;
    vectors++; if (if1.busy !== 1'b1) begin miscompares++; $display("FAIL basic_busy_accept: got %0b expected 1", if1.busy); end
    for (int n = 1; n <= 7; n++) begin
      @(negedge clk);
      if (n <= 4) begin
        vectors++;
        if (if1.dac_code !== exp_trial[n-1]) begin
          miscompares++;
          $display("FAIL basic_trial edge %0d: got %0d expected %0d", n, if1.dac_code, exp_trial[n-1]);
        end
      end
      vectors++;
      if (if1.done !== (n == 6)) begin
        miscompares++;
        $display("FAIL basic_done edge %0d: got %0b expected %0b", n, if1.done, (n == 6));
      end
      if (n == 5) begin
        vectors++; if (if1.code !== 4'd0) begin miscompares++; $display("FAIL basic_code_held: got %0d expected 0", if1.code); end
      end
      if (n == 6) begin
        vectors++; if (if1.code !== 4'd5) begin miscompares++; $display("FAIL basic_code: got %0d expected 5", if1.code); end
        vectors++; if (if1.valid !== 1'b1) begin miscompares++; $display("FAIL basic_valid: got %0b expected 1", if1.valid); end
        vectors++; if (if1.busy !== 1'b0) begin miscompares++; $display("FAIL basic_busy_end: got %0b expected 0", if1.busy); end
        vectors++; if (if1.dac_code !== 4'd5) begin miscompares++; $display("FAIL basic_dac_final: got %0d expected 5", if1.dac_code); end
      end
      if (n == 7) begin
        vectors++; if (if1.valid !== 1'b1) begin miscompares++; $display("FAIL basic_valid_hold: got %0b expected 1", if1.valid); end
      end
    end
  endtask

  task automatic test_levels();
    logic [7:0] lvls [4];
    logic [3:0] exps [4];
    logic [3:0] res;
    int         lat;
    lvls = '{8'd0, 8'd255, 8'd136, 8'd135};
    exps = '{4'd0, 4'd15, 4'd8, 4'd7};
    for (int i = 0; i < 4; i++) begin
      run_conv(lvls[i], res, lat);
      vectors++;
      if (res !== exps[i]) begin
        miscompares++;
        $display("FAIL levels_code in=%0d: got %0d expected %0d", lvls[i], res, exps[i]);
      end
      vectors++;
      if (lat != 6) begin
        miscompares++;
        $display("FAIL levels_latency in=%0d: got %0d expected 6", lvls[i], lat);
      end
    end
  endtask

  task automatic test_back_to_back();
    if1.analog_in = 8'd200;
    if1.start     = 1'b1;
    for (int n = 0; n <= 27; n++) begin
      @(negedge clk);
      vectors++;
      if (if1.done !== ((n % 7) == 6)) begin
        miscompares++;
        $display("FAIL b2b_done edge %0d: got %0b expected %0b", n, if1.done, ((n % 7) == 6));
      end
      if ((n % 7) == 6) begin
        vectors++;
        if (if1.code !== 4'd11) begin
          miscompares++;
          $display("FAIL b2b_code edge %0d: got %0d expected 11", n, if1.code);
        end
      end
      if (n == 7) begin
        vectors++; if (if1.valid !== 1'b0) begin miscompares++; $display("FAIL b2b_valid_clear: got %0b expected 0", if1.valid); end
        vectors++; if (if1.busy !== 1'b1) begin miscompares++; $display("FAIL b2b_busy_restart: got %0b expected 1", if1.busy); end
      end
    end
    if1.start = 1'b0;
    @(negedge clk);
    // Stray start pulses during a conversion must neither restart nor queue one.
    if1.analog_in = 8'd135;
    if1.start     = 1'b1;
    @(negedge clk);
    if1.start = 1'b0;
    for (int n = 1; n <= 14; n++) begin
      @(negedge clk);
      vectors++;
      if (if1.done !== (n == 6)) begin
        miscompares++;
        $display("FAIL pulse_done edge %0d: got %0b expected %0b", n, if1.done, (n == 6));
      end
      if (n == 6) begin
        vectors++; if (if1.code !== 4'd7) begin miscompares++; $display("FAIL pulse_code: got %0d expected 7", if1.code); end
      end
      if (n == 10) begin
        vectors++; if (if1.busy !== 1'b0) begin miscompares++; $display("FAIL pulse_busy_idle: got %0b expected 0", if1.busy); end
      end
      if1.start = (n == 2) || (n == 4);
    end
    if1.start = 1'b0;
  endtask

  task automatic test_reset_mid();
    logic [3:0] res;
    int         lat;
    if1.analog_in = 8'd100;
    if1.start     = 1'b1;
    @(negedge clk);
    if1.start = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    vectors++; if (if1.dac_code !== 4'd0) begin miscompares++; $display("FAIL rstmid_dac_code: got %0d expected 0", if1.dac_code); end
    vectors++; if (if1.code !== 4'd0) begin miscompares++; $display("FAIL rstmid_code: got %0d expected 0", if1.code); end
    vectors++; if (if1.busy !== 1'b0) begin miscompares++; $display("FAIL rstmid_busy: got %0b expected 0", if1.busy); end
    vectors++; if (if1.done !== 1'b0) begin miscompares++; $display("FAIL rstmid_done: got %0b expected 0", if1.done); end
    vectors++; if (if1.valid !== 1'b0) begin miscompares++; $display("FAIL rstmid_valid: got %0b expected 0", if1.valid); end
    run_conv(8'd50, res, lat);
    vectors++; if (res !== 4'd2) begin miscompares++; $display("FAIL rstmid_code_after: got %0d expected 2", res); end
    vectors++; if (lat != 6) begin miscompares++; $display("FAIL rstmid_latency: got %0d expected 6", lat); end
  endtask

  task automatic test_settle3();
    logic [3:0] exp_dac;
    if3.analog_in = 8'd170;
    if3.start     = 1'b1;
    @(negedge clk);
    if3.start = 1'b0;
    for (int n = 1; n <= 15; n++) begin
      @(negedge clk);
      if (n <= 13) begin
        if (n <= 3) exp_dac = 4'd8;
        else if (n <= 6) exp_dac = 4'd12;
        else if (n <= 9) exp_dac = 4'd10;
        else if (n <= 12) exp_dac = 4'd11;
        else exp_dac = 4'd10;
        vectors++;
        if (if3.dac_code !== exp_dac) begin
          miscompares++;
          $display("FAIL settle3_trial edge %0d: got %0d expected %0d", n, if3.dac_code, exp_dac);
        end
      end
      vectors++;
      if (if3.done !== (n == 14)) begin
        miscompares++;
        $display("FAIL settle3_done edge %0d: got %0b expected %0b", n, if3.done, (n == 14));
      end
      if (n == 14) begin
        vectors++; if (if3.code !== 4'd10) begin miscompares++; $display("FAIL settle3_code: got %0d expected 10", if3.code); end
        vectors++; if (if3.valid !== 1'b1) begin miscompares++; $display("FAIL settle3_valid: got %0b expected 1", if3.valid); end
      end
    end
  endtask

  task automatic test_input_change();
    int found;
    found         = 0;
    if1.analog_in = 8'd100;
    if1.start     = 1'b1;
    @(negedge clk);
    if1.start = 1'b0;
    @(negedge clk);
    if1.analog_in = 8'd255;
    for (int n = 2; n <= 40; n++) begin
      @(negedge clk);
      if (if1.done) begin
        found = n;
        break;
      end
    end
    vectors++; if (found != 6) begin miscompares++; $display("FAIL inchg_latency: got %0d expected 6", found); end
    vectors++; if (if1.code !== 4'd5) begin miscompares++; $display("FAIL inchg_code: got %0d expected 5", if1.code); end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_levels();
    test_back_to_back();
    test_reset_mid();
    test_settle3();
    test_input_change();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
